reg_file: RTL and testbench

Architectural register file with rename tags, directly downstream of the ROB commit port and upstream of dispatch operand fetch. It holds 32 × 32-bit integer registers, each with a ROB alias tag marking the in-flight producer. Dispatch reads two source operands combinationally and renames a destination. The ROB retires results into it and can flush all tags on rollback.

---
 rtl/reg_file_pkg.sv | 14 +
 rtl/reg_file_if.sv | 42 ++++
 rtl/reg_read_port.sv | 33 +++
 rtl/reg_file.sv | 77 +++++++
 tb/tb_reg_file.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and constants for the architectural register file.
// Imported by the interface, the read port and the top.
package reg_file_pkg;

  localparam int ROB_WIDTH = 4;
  localparam int REG_NUM   = 32;

  typedef logic [31:0]          data_t;
  typedef logic [4:0]           reg_t;
  typedef logic [ROB_WIDTH-1:0] rob_t;

  localparam rob_t NO_DEP = '0;

endpackage

// File: rtl/reg_file_if.sv
// ROB commit, dispatch rename and operand-fetch bundle.
// Master drives requests; slave is the register file.
interface reg_file_if;
  import reg_file_pkg::*;

  logic  rollback;
  logic  valid_from_rob;
  reg_t  reg_id_from_rob;
  rob_t  alias_from_rob;
  data_t result_from_rob;
  logic  valid_from_disp;
  reg_t  rd_from_disp;
  rob_t  alias_from_disp;
  reg_t  rs1_from_disp;
  reg_t  rs2_from_disp;
  rob_t  Qi_to_disp;
  data_t Vi_to_disp;
  rob_t  Qj_to_disp;
  data_t Vj_to_disp;

  modport master (
    output rollback, valid_from_rob,
    output reg_id_from_rob, alias_from_rob,
    output result_from_rob,
    output valid_from_disp, rd_from_disp,
    output alias_from_disp,
    output rs1_from_disp, rs2_from_disp,
    input  Qi_to_disp, Vi_to_disp,
    input  Qj_to_disp, Vj_to_disp
  );

  modport slave (
    input  rollback, valid_from_rob,
    input  reg_id_from_rob, alias_from_rob,
    input  result_from_rob,
    input  valid_from_disp, rd_from_disp,
    input  alias_from_disp,
    input  rs1_from_disp, rs2_from_disp,
    output Qi_to_disp, Vi_to_disp,
    output Qj_to_disp, Vj_to_disp
  );
endinterface

// File: rtl/reg_read_port.sv
// One operand read port: tag/data lookup with
// a same-cycle commit bypass.
module reg_read_port
  import reg_file_pkg::*;
(
  input  reg_t  rs_i,
  input  rob_t  tag_i,
  input  data_t data_i,
  input  logic  cvalid_i,
  input  reg_t  creg_i,
  input  rob_t  calias_i,
  input  data_t cres_i,
  output rob_t  q_o,
  output data_t v_o
);

  logic hit;

  assign hit = cvalid_i
            && (creg_i == rs_i)
            && (rs_i != '0)
            && (calias_i == tag_i);

  always_comb begin
    q_o = tag_i;
    v_o = data_i;
    if (hit) begin
      q_o = NO_DEP;
      v_o = cres_i;
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32x32 architectural register file with ROB alias tags,
// commit write, dispatch rename and rollback flush.
module reg_file
  import reg_file_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input logic       rdy,
  reg_file_if.slave bus
);

  data_t data_q [REG_NUM];
  data_t data_d [REG_NUM];
  rob_t  tag_q  [REG_NUM];
  rob_t  tag_d  [REG_NUM];

  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    if (rdy) begin
      if (bus.valid_from_rob
          && bus.reg_id_from_rob != '0) begin
        data_d[bus.reg_id_from_rob] =
          bus.result_from_rob;
        if (tag_q[bus.reg_id_from_rob]
            == bus.alias_from_rob)
          tag_d[bus.reg_id_from_rob] = NO_DEP;
      end
      // rename is applied after commit so it wins a collision
      if (bus.rollback) begin
        for (int i = 0; i < REG_NUM; i++)
          tag_d[i] = NO_DEP;
      end else if (bus.valid_from_disp
                   && bus.rd_from_disp != '0) begin
        tag_d[bus.rd_from_disp] =
          bus.alias_from_disp;
      end
    end
    data_d[0] = '0;
    tag_d[0]  = NO_DEP;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '{default: '0};
      tag_q  <= '{default: '0};
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

  reg_read_port u_rs1 (
    .rs_i     (bus.rs1_from_disp),
    .tag_i    (tag_q[bus.rs1_from_disp]),
    .data_i   (data_q[bus.rs1_from_disp]),
    .cvalid_i (bus.valid_from_rob),
    .creg_i   (bus.reg_id_from_rob),
    .calias_i (bus.alias_from_rob),
    .cres_i   (bus.result_from_rob),
    .q_o      (bus.Qi_to_disp),
    .v_o      (bus.Vi_to_disp)
  );

  reg_read_port u_rs2 (
    .rs_i     (bus.rs2_from_disp),
    .tag_i    (tag_q[bus.rs2_from_disp]),
    .data_i   (data_q[bus.rs2_from_disp]),
    .cvalid_i (bus.valid_from_rob),
    .creg_i   (bus.reg_id_from_rob),
    .calias_i (bus.alias_from_rob),
    .cres_i   (bus.result_from_rob),
    .q_o      (bus.Qj_to_disp),
    .v_o      (bus.Vj_to_disp)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file with a per-cycle
// reference model of the register/tag state.
module tb_reg_file;
  import reg_file_pkg::*;

  logic clk;
  logic rst;
  logic rdy;
  int   tests;
  int   fails;

  reg_file_if bus ();

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference state
  logic [31:0] m_data [32];
  logic [3:0]  m_tag  [32];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_data[i] = 0;
        m_tag[i]  = 0;
      end
    end else if (rdy) begin
      if (bus.valid_from_rob && bus.reg_id_from_rob != 0) begin
        m_data[bus.reg_id_from_rob] = bus.result_from_rob;
        if (m_tag[bus.reg_id_from_rob] == bus.alias_from_rob)
          m_tag[bus.reg_id_from_rob] = 0;
      end
      if (bus.rollback) begin
        for (int i = 0; i < 32; i++) m_tag[i] = 0;
      end else if (bus.valid_from_disp && bus.rd_from_disp != 0) begin
        m_tag[bus.rd_from_disp] = bus.alias_from_disp;
      end
    end
  end

  function automatic logic byp(input logic [4:0] rs);
    return bus.valid_from_rob && rs != 0
        && bus.reg_id_from_rob == rs
        && bus.alias_from_rob == m_tag[rs];
  endfunction

  function automatic logic [3:0] exp_q(input logic [4:0] rs);
    return byp(rs) ? 4'd0 : m_tag[rs];
  endfunction

  function automatic logic [31:0] exp_v(input logic [4:0] rs);
    return byp(rs) ? bus.result_from_rob : m_data[rs];
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    chk("model_Qi", 32'(bus.Qi_to_disp),
        32'(exp_q(bus.rs1_from_disp)));
    chk("model_Qj", 32'(bus.Qj_to_disp),
        32'(exp_q(bus.rs2_from_disp)));
    if (exp_q(bus.rs1_from_disp) == 0)
      chk("model_Vi", bus.Vi_to_disp, exp_v(bus.rs1_from_disp));
    if (exp_q(bus.rs2_from_disp) == 0)
      chk("model_Vj", bus.Vj_to_disp, exp_v(bus.rs2_from_disp));
  end

  task automatic clr();
    bus.rollback        = 0;
    bus.valid_from_rob  = 0;
    bus.reg_id_from_rob = 0;
    bus.alias_from_rob  = 0;
    bus.result_from_rob = 0;
    bus.valid_from_disp = 0;
    bus.rd_from_disp    = 0;
    bus.alias_from_disp = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ren(input logic [4:0] rd,
                     input logic [3:0] al);
    bus.valid_from_disp = 1;
    bus.rd_from_disp    = rd;
    bus.alias_from_disp = al;
  endtask

  task automatic cmt(input logic [4:0] id,
                     input logic [3:0] al,
                     input logic [31:0] v);
    bus.valid_from_rob  = 1;
    bus.reg_id_from_rob = id;
    bus.alias_from_rob  = al;
    bus.result_from_rob = v;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 0;
    rdy = 1;
    clr();
    bus.rs1_from_disp = 5;
    bus.rs2_from_disp = 0;
    #3;
    chk("rst_Qi", 32'(bus.Qi_to_disp), 0);
    chk("rst_Vi", bus.Vi_to_disp, 0);
    chk("rst_Qj", 32'(bus.Qj_to_disp), 0);
    chk("rst_Vj", bus.Vj_to_disp, 0);
    step();
    step();
    rst = 1;

    // rename then commit with bypass
    ren(3, 7);
    step();
    clr();
    bus.rs1_from_disp = 3;
    #1 chk("ren_Qi", 32'(bus.Qi_to_disp), 7);
    cmt(3, 7, 32'hDEADBEEF);
    #1 chk("byp_Qi", 32'(bus.Qi_to_disp), 0);
    chk("byp_Vi", bus.Vi_to_disp, 32'hDEADBEEF);
    step();
    clr();
    #1 chk("cmt_Qi", 32'(bus.Qi_to_disp), 0);
    chk("cmt_Vi", bus.Vi_to_disp, 32'hDEADBEEF);

    // stale commit keeps the younger tag
    ren(4, 2);
    step();
    ren(4, 5);
    step();
    clr();
    cmt(4, 2, 32'h11);
    bus.rs1_from_disp = 4;
    #1 chk("stale_byp_Qi", 32'(bus.Qi_to_disp), 5);
    step();
    clr();
    #1 chk("stale_Qi", 32'(bus.Qi_to_disp), 5);

    // commit and rename collide on x6
    ren(6, 3);
    step();
    cmt(6, 3, 32'h22);
    ren(6, 9);
    step();
    clr();
    bus.rs1_from_disp = 6;
    #1 chk("coll_Qi", 32'(bus.Qi_to_disp), 9);

    // rollback with a discarded rename
    ren(1, 1);
    step();
    ren(2, 2);
    step();
    ren(31, 15);
    step();
    clr();
    bus.rs1_from_disp = 1;
    bus.rs2_from_disp = 31;
    #1 chk("pre_rb_Qi", 32'(bus.Qi_to_disp), 1);
    chk("pre_rb_Qj", 32'(bus.Qj_to_disp), 15);
    bus.rollback = 1;
    ren(8, 4);
    step();
    clr();
    #1 chk("rb_Qi", 32'(bus.Qi_to_disp), 0);
    chk("rb_Qj", 32'(bus.Qj_to_disp), 0);
    bus.rs1_from_disp = 8;
    bus.rs2_from_disp = 2;
    #1 chk("rb_Q8", 32'(bus.Qi_to_disp), 0);
    chk("rb_Q2", 32'(bus.Qj_to_disp), 0);
    bus.rs1_from_disp = 4;
    bus.rs2_from_disp = 6;
    #1 chk("stale_Vi", bus.Vi_to_disp, 32'h11);
    chk("coll_Vj", bus.Vj_to_disp, 32'h22);

    // x0 is hardwired
    cmt(0, 1, 32'hFF);
    ren(0, 1);
    step();
    clr();
    bus.rs1_from_disp = 0;
    bus.rs2_from_disp = 0;
    #1 chk("x0_Qi", 32'(bus.Qi_to_disp), 0);
    chk("x0_Vi", bus.Vi_to_disp, 0);

    // rdy low holds state, reads stay live
    rdy = 0;
    ren(9, 3);
    cmt(3, 0, 32'h55);
    bus.rs1_from_disp = 3;
    bus.rs2_from_disp = 9;
    step();
    clr();
    #1 chk("rdy_V3", bus.Vi_to_disp, 32'hDEADBEEF);
    rdy = 1;
    #1 chk("rdy_Q9", 32'(bus.Qj_to_disp), 0);

    // mid-stream async reset
    ren(10, 6);
    step();
    clr();
    bus.rs2_from_disp = 10;
    #1 chk("pre_rst_Q10", 32'(bus.Qj_to_disp), 6);
    #1 rst = 0;
    #1 chk("arst_Vi", bus.Vi_to_disp, 0);
    chk("arst_Qj", 32'(bus.Qj_to_disp), 0);
    step();
    rst = 1;
    ren(10, 12);
    step();
    clr();
    #1 chk("post_rst_Q10", 32'(bus.Qj_to_disp), 12);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
